// File: rtl/adpll_lock_detect.sv
// Lock detector for the ADPLL loop-filter word: declares lock after a run of
// stable samples, loss after a run of unstable ones, and keeps debug counters.
module adpll_lock_detect #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       clk_ref,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] filter_out,
    input  logic       filter_sign,
    input  logic [2:0] tol,
    output logic       lock,
    output logic       lock_pulse,
    output logic       lost_pulse,
    output logic [1:0] state,
    output logic [7:0] acq_time,
    output logic [3:0] loss_cnt
);

    typedef enum logic [1:0] {
        ACQ    = 2'b00,
        LOCKED = 2'b01,
        HOLD   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_N  = 4'(UNLOCK_CNT);

    state_t     st, st_nxt;
    logic [5:0] prev, prev_nxt;
    logic       prev_vld, prev_vld_nxt;
    logic [7:0] run, run_nxt;
    logic [3:0] miss, miss_nxt;
    logic [7:0] acq_nxt;
    logic [3:0] loss_nxt;
    logic       lock_nxt, lock_pulse_nxt, lost_pulse_nxt;

    logic [5:0] cur;
    logic [6:0] delta;
    logic [5:0] delta_mag;
    logic       in_win;

    // Negating a zero magnitude yields zero, so negative zero folds to 0.
    assign cur       = filter_sign ? -{1'b0, filter_out} : {1'b0, filter_out};
    assign delta     = {cur[5], cur} - {prev[5], prev};
    assign delta_mag = delta[6] ? 6'(-delta) : delta[5:0];
    assign in_win    = (delta_mag <= {3'b000, tol});

    assign state = st;

    // NOTE: every variable gets its hold/default value first so that no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        st_nxt         = st;
        prev_nxt       = prev;
        prev_vld_nxt   = prev_vld;
        run_nxt        = run;
        miss_nxt       = miss;
        acq_nxt        = acq_time;
        loss_nxt       = loss_cnt;
        lock_nxt       = lock;
        lock_pulse_nxt = 1'b0;
        lost_pulse_nxt = 1'b0;

        if (en) begin
            prev_nxt     = cur;
            prev_vld_nxt = 1'b1;
            if (st == ACQ && acq_time != 8'hFF)
                acq_nxt = acq_time + 8'd1;

            if (st == UNUSED) begin
                st_nxt   = ACQ;
                lock_nxt = 1'b0;
                run_nxt  = '0;
                miss_nxt = '0;
            end else if (prev_vld) begin
                case (st)
                    ACQ: begin
                        if (!in_win) begin
                            run_nxt = '0;
                        end else if (run == LOCK_LAST) begin
                            st_nxt         = LOCKED;
                            lock_nxt       = 1'b1;
                            lock_pulse_nxt = 1'b1;
                            run_nxt        = '0;
                        end else begin
                            run_nxt = run + 8'd1;
                        end
                    end
                    LOCKED, HOLD: begin
                        if (in_win) begin
                            st_nxt   = LOCKED;
                            miss_nxt = '0;
                        end else if (((st == LOCKED) ? 4'd1 : miss + 4'd1) == UNLOCK_N) begin
                            st_nxt         = ACQ;
                            lock_nxt       = 1'b0;
                            lost_pulse_nxt = 1'b1;
                            run_nxt        = '0;
                            miss_nxt       = '0;
                            acq_nxt        = '0;
                            if (loss_cnt != 4'hF)
                                loss_nxt = loss_cnt + 4'd1;
                        end else begin
                            st_nxt   = HOLD;
                            miss_nxt = (st == LOCKED) ? 4'd1 : miss + 4'd1;
                        end
                    end
                    default: st_nxt = ACQ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_ref or posedge clr) begin
        if (clr) begin
            st         <= ACQ;
            prev       <= '0;
            prev_vld   <= 1'b0;
            run        <= '0;
            miss       <= '0;
            acq_time   <= '0;
            loss_cnt   <= '0;
            lock       <= 1'b0;
            lock_pulse <= 1'b0;
            lost_pulse <= 1'b0;
        end else begin
            st         <= st_nxt;
            prev       <= prev_nxt;
            prev_vld   <= prev_vld_nxt;
            run        <= run_nxt;
            miss       <= miss_nxt;
            acq_time   <= acq_nxt;
            loss_cnt   <= loss_nxt;
            lock       <= lock_nxt;
            lock_pulse <= lock_pulse_nxt;
            lost_pulse <= lost_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed bench for adpll_lock_detect: table of alternating-word scenarios
// plus hand-written loss, reset, enable and saturation sequences.
module tb_adpll_lock_detect;

    logic       clk_ref = 1'b0;
    logic       clr;
    logic       en;
    logic [4:0] filter_out;
    logic       filter_sign;
    logic [2:0] tol;
    logic       lock, lock_pulse, lost_pulse;
    logic [1:0] state;
    logic [7:0] acq_time;
    logic [3:0] loss_cnt;

    int checks = 0;
    int errors = 0;

    adpll_lock_detect dut (
        .clk_ref    (clk_ref),
        .clr        (clr),
        .en         (en),
        .filter_out (filter_out),
        .filter_sign(filter_sign),
        .tol        (tol),
        .lock       (lock),
        .lock_pulse (lock_pulse),
        .lost_pulse (lost_pulse),
        .state      (state),
        .acq_time   (acq_time),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic       a_sign;
        logic [4:0] a_mag;
        logic       b_sign;
        logic [4:0] b_mag;
        logic [2:0] tol;
        int         edges;
        logic       exp_lock;
        logic       exp_pulse;
        logic [1:0] exp_state;
        logic [7:0] exp_acq;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic [4:0] m);
        filter_sign = s;
        filter_out  = m;
        @(posedge clk_ref);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    initial begin
        // a/b alternate each edge, starting with a on the prev-load edge
        vecs[0] = '{1'b0, 5'd7,  1'b0, 5'd7,  3'd1, 17,  1'b1, 1'b1, 2'b01, 8'd17};
        vecs[1] = '{1'b0, 5'd7,  1'b0, 5'd7,  3'd1, 16,  1'b0, 1'b0, 2'b00, 8'd16};
        vecs[2] = '{1'b0, 5'd3,  1'b0, 5'd5,  3'd2, 17,  1'b1, 1'b1, 2'b01, 8'd17};
        vecs[3] = '{1'b0, 5'd3,  1'b0, 5'd6,  3'd2, 300, 1'b0, 1'b0, 2'b00, 8'd255};
        vecs[4] = '{1'b0, 5'd1,  1'b1, 5'd0,  3'd1, 17,  1'b1, 1'b1, 2'b01, 8'd17};
        vecs[5] = '{1'b0, 5'd1,  1'b1, 5'd1,  3'd1, 40,  1'b0, 1'b0, 2'b00, 8'd40};
        vecs[6] = '{1'b1, 5'd5,  1'b1, 5'd3,  3'd2, 17,  1'b1, 1'b1, 2'b01, 8'd17};
        vecs[7] = '{1'b0, 5'd15, 1'b1, 5'd15, 3'd7, 20,  1'b0, 1'b0, 2'b00, 8'd20};
        vecs[8] = '{1'b1, 5'd0,  1'b0, 5'd0,  3'd0, 17,  1'b1, 1'b1, 2'b01, 8'd17};
        vecs[9] = '{1'b0, 5'd31, 1'b1, 5'd31, 3'd7, 10,  1'b0, 1'b0, 2'b00, 8'd10};

        clr = 1'b1; en = 1'b0; filter_out = '0; filter_sign = 1'b0; tol = 3'd1;
        repeat (2) @(posedge clk_ref);
        #1;
        check("rst_lock", {31'd0, lock}, 32'd0);
        check("rst_lock_pulse", {31'd0, lock_pulse}, 32'd0);
        check("rst_lost_pulse", {31'd0, lost_pulse}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_acq", {24'd0, acq_time}, 32'd0);
        check("rst_loss", {28'd0, loss_cnt}, 32'd0);
        clr = 1'b0;
        en  = 1'b1;

        for (int v = 0; v < 10; v++) begin
            pulse_clr();
            tol = vecs[v].tol;
            for (int e = 0; e < vecs[v].edges; e++) begin
                if (e % 2 == 0) step(vecs[v].a_sign, vecs[v].a_mag);
                else            step(vecs[v].b_sign, vecs[v].b_mag);
            end
            check($sformatf("vec%0d_lock", v), {31'd0, lock}, {31'd0, vecs[v].exp_lock});
            check($sformatf("vec%0d_lock_pulse", v), {31'd0, lock_pulse}, {31'd0, vecs[v].exp_pulse});
            check($sformatf("vec%0d_state", v), {30'd0, state}, {30'd0, vecs[v].exp_state});
            check($sformatf("vec%0d_acq", v), {24'd0, acq_time}, {24'd0, vecs[v].exp_acq});
            check($sformatf("vec%0d_loss", v), {28'd0, loss_cnt}, 32'd0);
        end

        // Loss: lock on 5, three outliers then recovery, then four outliers.
        pulse_clr();
        tol = 3'd1;
        repeat (17) step(1'b0, 5'd5);
        check("loss_locked", {31'd0, lock}, 32'd1);
        step(1'b0, 5'd13);
        check("hold1_state", {30'd0, state}, 32'd2);
        step(1'b0, 5'd5);
        step(1'b0, 5'd13);
        check("hold3_state", {30'd0, state}, 32'd2);
        check("hold3_lock", {31'd0, lock}, 32'd1);
        step(1'b0, 5'd13);
        check("recover_state", {30'd0, state}, 32'd1);
        check("recover_lock", {31'd0, lock}, 32'd1);
        step(1'b0, 5'd5);
        step(1'b0, 5'd13);
        step(1'b0, 5'd5);
        check("miss3_lock", {31'd0, lock}, 32'd1);
        check("miss3_lost", {31'd0, lost_pulse}, 32'd0);
        step(1'b0, 5'd13);
        check("loss_lock", {31'd0, lock}, 32'd0);
        check("loss_pulse", {31'd0, lost_pulse}, 32'd1);
        check("loss_cnt1", {28'd0, loss_cnt}, 32'd1);
        check("loss_state", {30'd0, state}, 32'd0);
        check("loss_acq", {24'd0, acq_time}, 32'd0);
        step(1'b0, 5'd13);
        check("loss_pulse_end", {31'd0, lost_pulse}, 32'd0);
        check("loss_acq_restart", {24'd0, acq_time}, 32'd1);

        // Relock without a prev reload: 16 in-window edges in total.
        repeat (15) step(1'b0, 5'd13);
        check("relock_lock", {31'd0, lock}, 32'd1);
        check("relock_pulse", {31'd0, lock_pulse}, 32'd1);
        check("relock_acq", {24'd0, acq_time}, 32'd16);

        // Asynchronous clear mid-lock, between edges.
        #2;
        clr = 1'b1;
        #1;
        check("aclr_lock", {31'd0, lock}, 32'd0);
        check("aclr_lock_pulse", {31'd0, lock_pulse}, 32'd0);
        check("aclr_lost_pulse", {31'd0, lost_pulse}, 32'd0);
        check("aclr_state", {30'd0, state}, 32'd0);
        check("aclr_loss", {28'd0, loss_cnt}, 32'd0);
        clr = 1'b0;
        repeat (16) step(1'b0, 5'd13);
        check("aclr_relock16", {31'd0, lock}, 32'd0);
        step(1'b0, 5'd13);
        check("aclr_relock17", {31'd0, lock}, 32'd1);
        check("aclr_relock_acq", {24'd0, acq_time}, 32'd17);

        // Pulse clears on the next edge even with en low.
        en = 1'b0;
        step(1'b0, 5'd13);
        check("en_pulse_clear", {31'd0, lock_pulse}, 32'd0);
        check("en_pulse_lock", {31'd0, lock}, 32'd1);
        en = 1'b1;

        // en low during ACQ holds run, acq_time, state and prev.
        pulse_clr();
        repeat (5) step(1'b0, 5'd7);
        en = 1'b0;
        repeat (10) step(1'b0, 5'd20);
        check("en_hold_acq", {24'd0, acq_time}, 32'd5);
        check("en_hold_state", {30'd0, state}, 32'd0);
        en = 1'b1;
        repeat (11) step(1'b0, 5'd7);
        check("en_resume_early", {31'd0, lock}, 32'd0);
        step(1'b0, 5'd7);
        check("en_resume_lock", {31'd0, lock}, 32'd1);
        check("en_resume_acq", {24'd0, acq_time}, 32'd17);

        // Sixteen lock/loss cycles saturate loss_cnt.
        pulse_clr();
        step(1'b0, 5'd5);
        for (int i = 0; i < 16; i++) begin
            repeat (16) step(1'b0, 5'd5);
            check($sformatf("sat%0d_lock", i), {31'd0, lock}, 32'd1);
            step(1'b0, 5'd13);
            step(1'b0, 5'd5);
            step(1'b0, 5'd13);
            step(1'b0, 5'd5);
            if (i == 14)
                check("sat_loss15", {28'd0, loss_cnt}, 32'd15);
        end
        check("sat_loss16", {28'd0, loss_cnt}, 32'd15);
        check("sat_final_lock", {31'd0, lock}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
